// File: rtl/banked_ram_if.sv
// Request/response bus of banked_ram: valid/ready request port, fixed-latency read response.
// Parity error-injection and per-byte parity flags exist only with BANKED_RAM_PARITY_EN.
interface banked_ram_if #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 16
) ();

    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_be;
    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    busy;
`ifdef BANKED_RAM_PARITY_EN
    logic                    err_inject;
    logic [DATA_WIDTH/8-1:0] rsp_perr;
`endif

    modport master (
`ifdef BANKED_RAM_PARITY_EN
        output err_inject,
        input  rsp_perr,
`endif
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        output req_be,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  busy
    );

    modport slave (
`ifdef BANKED_RAM_PARITY_EN
        input  err_inject,
        output rsp_perr,
`endif
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        input  req_be,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output busy
    );

endinterface

// File: rtl/banked_ram.sv
// Word-addressed RAM split into NUM_BANKS interleaved banks with byte enables, a pipelined
// read channel and an optional zeroing sweep after reset. Parity: BANKED_RAM_PARITY_EN.
module banked_ram #(
    parameter int unsigned ADDR_WIDTH     = 13,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned NUM_BANKS      = 2,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input logic         clk,
    input logic         rst,
    banked_ram_if.slave bus
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    localparam int unsigned BANK_BITS = $clog2(NUM_BANKS);
    localparam int unsigned BANK_W    = (BANK_BITS == 0) ? 1 : BANK_BITS;
    localparam int unsigned ROW_W     = ADDR_WIDTH - BANK_BITS;
    localparam int unsigned ROWS      = 2 ** ROW_W;

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e           state_q, state_d;
    logic [ROW_W-1:0] clr_row_q, clr_row_d;

    logic              req_acc, wr_acc, rd_acc;
    logic [BANK_W-1:0] req_bank;
    logic [ROW_W-1:0]  req_row;

    logic [DATA_WIDTH-1:0] mem_q [NUM_BANKS][ROWS];
    logic [DATA_WIDTH-1:0] rd_word;

    logic [READ_LATENCY-1:0] pipe_vld_q;
    logic [DATA_WIDTH-1:0]   pipe_data_q [READ_LATENCY];

    // Low address bits pick the bank so consecutive words land in different banks.
    assign req_bank = BANK_W'(bus.req_addr & ADDR_WIDTH'(NUM_BANKS - 1));
    assign req_row  = ROW_W'(bus.req_addr >> BANK_BITS);

    assign req_acc = bus.req_valid && bus.req_ready;
    assign wr_acc  = req_acc && bus.req_we;
    assign rd_acc  = req_acc && !bus.req_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? StClear : StReady;
            clr_row_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_row_q <= clr_row_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_row_d = clr_row_q;
        unique case (state_q)
            StClear: begin
                clr_row_d = clr_row_q + 1'b1;
                if (&clr_row_q) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                state_d = StReady;
            end
        endcase
    end

    // Ready is masked by rst so nothing is accepted on a reset edge.
    always_comb begin
        bus.req_ready = 1'b0;
        bus.busy      = 1'b0;
        unique case (state_q)
            StClear: bus.busy      = 1'b1;
            StReady: bus.req_ready = !rst;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                mem_q[b][clr_row_q] <= '0;
            end
        end else if (wr_acc) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (bus.req_be[i]) begin
                    mem_q[req_bank][req_row][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rd_word = mem_q[req_bank][req_row];

    // Each stage only loads when its predecessor is valid, so the last stage holds rsp_rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= rd_acc;
            if (rd_acc) begin
                pipe_data_q[0] <= rd_word;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                if (pipe_vld_q[i-1]) begin
                    pipe_data_q[i] <= pipe_data_q[i-1];
                end
            end
        end
    end

    assign bus.rsp_valid = pipe_vld_q[READ_LATENCY-1];
    assign bus.rsp_rdata = pipe_data_q[READ_LATENCY-1];

`ifdef BANKED_RAM_PARITY_EN
    logic [NUM_BYTES-1:0] par_q [NUM_BANKS][ROWS];
    logic [NUM_BYTES-1:0] rd_perr;
    logic [NUM_BYTES-1:0] pipe_perr_q [READ_LATENCY];

    // Even parity: stored bit is the XOR of the byte, optionally inverted for error injection.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                par_q[b][clr_row_q] <= '0;
            end
        end else if (wr_acc) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (bus.req_be[i]) begin
                    par_q[req_bank][req_row][i] <= (^bus.req_wdata[8*i +: 8]) ^ bus.err_inject;
                end
            end
        end
    end

    always_comb begin
        rd_perr = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            rd_perr[i] = (^rd_word[8*i +: 8]) ^ par_q[req_bank][req_row][i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_perr_q[i] <= '0;
            end
        end else begin
            if (rd_acc) begin
                pipe_perr_q[0] <= rd_perr;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                if (pipe_vld_q[i-1]) begin
                    pipe_perr_q[i] <= pipe_perr_q[i-1];
                end
            end
        end
    end

    assign bus.rsp_perr = pipe_perr_q[READ_LATENCY-1];
`endif

endmodule

// File: tb/tb_banked_ram.sv
// Directed self-checking bench for banked_ram: clear sweep, byte enables, pipelining,
// read-after-write, reset mid-operation and (with BANKED_RAM_PARITY_EN) parity flags.
module tb_banked_ram;

    localparam int unsigned AW  = 4;
    localparam int unsigned DW  = 16;
    localparam int unsigned NB  = 2;
    localparam int unsigned RL  = 3;
    localparam int unsigned COR = 1;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] rd_data;
    int            rd_lat;
    int            n_busy;
    int            n_pulse;
    logic          vld_log [8];
    logic [DW-1:0] dat_log [8];
`ifdef BANKED_RAM_PARITY_EN
    logic [DW/8-1:0] rd_perr;
`endif

    banked_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    banked_ram #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .NUM_BANKS     (NB),
        .READ_LATENCY  (RL),
        .CLEAR_ON_RESET(COR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW/8-1:0] be, input logic inj);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_be    = be;
`ifdef BANKED_RAM_PARITY_EN
        bus.err_inject = inj;
`else
        if (inj) bus.req_be = be;
`endif
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
`ifdef BANKED_RAM_PARITY_EN
        bus.err_inject = 1'b0;
`endif
    endtask

    // lat counts cycles from the accept edge to the sample that sees rsp_valid.
    task automatic do_read(input logic [AW-1:0] a);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = a;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rd_lat = 1;
        while (!bus.rsp_valid && rd_lat < 20) begin
            @(posedge clk);
            #1;
            rd_lat++;
        end
        rd_data = bus.rsp_rdata;
`ifdef BANKED_RAM_PARITY_EN
        rd_perr = bus.rsp_perr;
`endif
    endtask

    // Counts busy cycles (and any stray responses) until the sweep finishes.
    task automatic wait_clear();
        n_busy = 0;
        while (bus.busy && n_busy < 100) begin
            if (bus.rsp_valid) n_pulse++;
            n_busy++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
`ifdef BANKED_RAM_PARITY_EN
        bus.err_inject = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'd1);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);

        n_pulse = 0;
        wait_clear();
        check("clear_len", 32'(n_busy), 32'd8);
        check("clear_ready", 32'(bus.req_ready), 32'd1);
        check("clear_busy_low", 32'(bus.busy), 32'd0);

        for (int a = 0; a < 16; a++) begin
            do_read(AW'(a));
            check($sformatf("clear_rd_%0d", a), 32'(rd_data), 32'h0);
        end
        check("clear_rd_lat", 32'(rd_lat), 32'(RL));

        // Byte enables
        do_write(4'd5, 16'hABCD, 2'b11, 1'b0);
        do_write(4'd5, 16'h1200, 2'b10, 1'b0);
        do_read(4'd5);
        check("be_merge", 32'(rd_data), 32'h12CD);
        check("be_lat", 32'(rd_lat), 32'(RL));
        @(posedge clk);
        #1;
        check("rsp_single_pulse", 32'(bus.rsp_valid), 32'd0);
        check("rsp_hold", 32'(bus.rsp_rdata), 32'h12CD);

        // be=0 is a no-op and writes never respond
        do_write(4'd5, 16'hFFFF, 2'b00, 1'b0);
        n_pulse = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.rsp_valid) n_pulse++;
            @(posedge clk);
            #1;
        end
        check("write_no_rsp", 32'(n_pulse), 32'd0);
        do_read(4'd5);
        check("be_zero_noop", 32'(rd_data), 32'h12CD);

        // Back-to-back reads through the pipeline
        for (int a = 0; a < 4; a++) do_write(AW'(a), 16'(16'h1000 + a), 2'b11, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 4'd0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (k < 3) bus.req_addr = AW'(k + 1);
            else bus.req_valid = 1'b0;
            vld_log[k] = bus.rsp_valid;
            dat_log[k] = bus.rsp_rdata;
        end
        for (int k = 0; k < 8; k++) begin
            check($sformatf("pipe_vld_%0d", k), 32'(vld_log[k]),
                  (k >= 2 && k <= 5) ? 32'd1 : 32'd0);
        end
        for (int k = 2; k < 6; k++) begin
            check($sformatf("pipe_data_%0d", k - 2), 32'(dat_log[k]), 32'(16'h1000 + k - 2));
        end

        // Read-after-write and bank interleave
        do_write(4'd6, 16'h5555, 2'b11, 1'b0);
        do_read(4'd6);
        check("raw_addr6", 32'(rd_data), 32'h5555);
        do_write(4'd7, 16'h7777, 2'b11, 1'b0);
        do_read(4'd6);
        check("interleave_addr6", 32'(rd_data), 32'h5555);
        do_read(4'd7);
        check("interleave_addr7", 32'(rd_data), 32'h7777);

        // Request fields ignored without req_valid
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b1;
        bus.req_addr  = 4'd6;
        bus.req_wdata = 16'h0000;
        bus.req_be    = 2'b11;
        @(posedge clk);
        #1;
        bus.req_we = 1'b0;
        do_read(4'd6);
        check("no_valid_ignored", 32'(rd_data), 32'h5555);

        // Reset with a read in flight, then a second reset mid-sweep
        do_write(4'd9, 16'h3333, 2'b11, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 4'd9;
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 4'd0;
        bus.req_wdata = 16'hFFFF;
        bus.req_be    = 2'b11;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_rdata", 32'(bus.rsp_rdata), 32'h0);
        n_pulse = 0;
        for (int k = 0; k < 3; k++) begin
            if (bus.rsp_valid) n_pulse++;
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_clear();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        check("midrst_no_rsp", 32'(n_pulse), 32'd0);
        check("midsweep_restart_len", 32'(n_busy), 32'd8);
        do_read(4'd0);
        check("clear_drops_req", 32'(rd_data), 32'h0);
        do_read(4'd9);
        check("midrst_cleared", 32'(rd_data), 32'h0);

`ifdef BANKED_RAM_PARITY_EN
        do_write(4'd2, 16'h00FF, 2'b01, 1'b1);
        do_read(4'd2);
        check("perr_injected", 32'(rd_perr), 32'h1);
        do_write(4'd2, 16'h00FF, 2'b01, 1'b0);
        do_read(4'd2);
        check("perr_clean", 32'(rd_perr), 32'h0);
        check("perr_data", 32'(rd_data), 32'h00FF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/banked_ram.md
Name: banked_ram

Overview:
- Parametrised successor to the team's single-port byte RAM.
- Word-addressed memory split into NUM_BANKS interleaved banks.
- Per-byte write enables, a valid/ready request port and a pipelined read-response channel with fixed latency.
- Optional hardware clear sweep after reset; serves as the CPU-side data/instruction store in the project datapath.

Parameters:
ADDR_WIDTH, 13, word address width; total depth 2^ADDR_WIDTH words
DATA_WIDTH, 16, word width in bits; must be a multiple of 8
NUM_BANKS, 2, bank count; power of 2, 1..8
READ_LATENCY, 1, cycles from read accept to rsp_valid; legal range 1..4
CLEAR_ON_RESET, 1, 1 = zero all memory after reset; 0 = go straight to READY

Ports:
clk  input  1  clock; all state changes on posedge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_WIDTH  word address
req_wdata  input  DATA_WIDTH  write data
req_be  input  DATA_WIDTH/8  byte enables; bit i covers bits [8i+7:8i]
rsp_valid  output  1  read data valid, single-cycle pulse
rsp_rdata  output  DATA_WIDTH  read data
busy  output  1  clear sweep in progress

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Address decode: bank = req_addr[log2(NUM_BANKS)-1:0], row = remaining upper bits; every address is valid.
- Reset (rst high at a posedge):
  - req_ready=0, rsp_valid=0, rsp_rdata=0.
  - Read pipeline flushed; reads in flight produce no response.
  - busy=1 if CLEAR_ON_RESET, else 0.
  - Memory contents untouched by reset itself.
- FSM states: CLEAR, READY.
  - rst -> CLEAR when CLEAR_ON_RESET=1, else -> READY.
- CLEAR:
  - Row counter runs 0..DEPTH/NUM_BANKS-1, one row per cycle, writing 0 to that row in all banks simultaneously.
  - After the last row, the next cycle enters READY with busy=0 and req_ready=1.
  - Sweep length is exactly 2^ADDR_WIDTH/NUM_BANKS cycles.
  - req_ready=0 throughout; requests are ignored and not queued.
  - rst asserted mid-sweep restarts the sweep from row 0.
- READY:
  - req_ready=1 continuously, one request accepted per cycle (req_valid && req_ready at a posedge).
  - Write: only bytes with req_be set are updated; others are preserved. req_be=0 is accepted as a no-op.
  - Read: rsp_valid=1 for exactly one cycle, READ_LATENCY cycles after the accept edge. rsp_rdata carries the word as of the accept edge.
  - Responses arrive in request order. Back-to-back reads give back-to-back responses.
  - There is no response backpressure.
- Read-after-write: a write accepted at edge N followed by a read of the same address at edge N+1 returns the new data.
- rsp_rdata holds its last value while rsp_valid=0.
- Writes never produce a response.
- req_* inputs are ignored when req_valid=0.

Optional Feature:
BANKED_RAM_PARITY_EN
- With the macro defined:
  - One even-parity bit is stored per byte.
  - New input err_inject (1 bit): when high on an accepted write, stored parity for the enabled bytes is inverted.
  - New output rsp_perr (DATA_WIDTH/8 bits) is valid with rsp_valid; bit i=1 flags a parity mismatch on byte i. It is 0 at reset and held like rsp_rdata.
  - CLEAR writes parity 0, which is consistent with zero data.
- Without the macro: no parity storage; ports err_inject and rsp_perr are absent.

Test Plan:
- Reset clear (ADDR_WIDTH=4, NUM_BANKS=2, CLEAR_ON_RESET=1): rst for 1 cycle -> busy=1 and req_ready=0 for exactly 8 cycles, then READY; reads of addr 0..15 all return 0x0000.
- Byte enables: write 0xABCD be=2'b11 to addr 5, then write 0x1200 be=2'b10 to addr 5, then read addr 5 -> rsp_rdata=0x12CD, READ_LATENCY cycles after the read accept.
- Pipelining (READ_LATENCY=3): after writing addr 0..3 with 0x1000..0x1003, reads issued on 4 consecutive cycles -> rsp_valid high for 4 consecutive cycles starting 3 cycles after the first accept, with data 0x1000..0x1003 in order.
- Read-after-write and bank interleave: write 0x5555 to addr 6 (bank 0) at edge N and read addr 6 at edge N+1 -> 0x5555; write 0x7777 to addr 7 (bank 1) -> addr 6 still reads 0x5555.
- Reset mid-operation: issue a read, assert rst before the response is due -> no rsp_valid pulse; clear restarts from row 0; request during CLEAR with req_valid=1 is dropped and memory is unchanged.
- Parity (BANKED_RAM_PARITY_EN): write 0x00FF be=2'b01 with err_inject=1, then read -> rsp_perr=2'b01; rewrite the same address with err_inject=0 -> rsp_perr=2'b00.
